// File: rtl/updown_counter_pkg.sv
// Shared types, defaults and next-state helper for updown_counter.
// The helper works on MAX_WIDTH-bit values so any WIDTH up to MAX_WIDTH can use it;
// callers truncate the result back to WIDTH, which yields the modulo 2**WIDTH wrap.
package updown_counter_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;
    localparam int unsigned MAX_WIDTH     = 64;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Priority: load, then count in the selected direction, else hold.
    function automatic logic [MAX_WIDTH-1:0] next_count(
        input logic [MAX_WIDTH-1:0] q,
        input logic [MAX_WIDTH-1:0] data,
        input logic                 en,
        input logic                 ld,
        input dir_e                 updn
    );
        logic [MAX_WIDTH-1:0] nxt;
        nxt = q;
        if (ld) begin
            nxt = data;
        end else if (en) begin
            if (updn == DIR_UP) begin
                nxt = q + MAX_WIDTH'(1);
            end else begin
                nxt = q - MAX_WIDTH'(1);
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/updown_counter.sv
// Loadable, enable-gated WIDTH-bit up/down counter with asynchronous active-high reset.
// WIDTH must lie in 2..MAX_WIDTH.
// Optional feature macro: UPDOWN_COUNTER_TC_EN adds the terminal-count output TC after Q.
// Port order (Clock, Reset, Enable, Load, UpDn, Data, Q) is kept for positional use.
module updown_counter
    import updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             Load,
    input  logic             UpDn,
    input  logic [WIDTH-1:0] Data,
    output logic [WIDTH-1:0] Q
`ifdef UPDOWN_COUNTER_TC_EN
    ,
    output logic             TC
`endif
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_next;

    // Resolve load/count/hold priority; truncation to WIDTH provides the wrap.
    always_comb begin
        count_next = WIDTH'(next_count(MAX_WIDTH'(count), MAX_WIDTH'(Data), Enable, Load,
                                       dir_e'(UpDn)));
    end

    // Counter state; reset clears it immediately, independent of Clock.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    assign Q = count;

`ifdef UPDOWN_COUNTER_TC_EN
    // High when the coming edge wraps the counter; forced low during reset.
    assign TC = ~Reset & Enable & ~Load &
                ((UpDn & (count == {WIDTH{1'b1}})) | (~UpDn & (count == {WIDTH{1'b0}})));
`endif

endmodule

// File: tb/tb_updown_counter.sv
// Scoreboard bench for updown_counter: the stimulus process pushes expected values tagged
// with the sample slot at which they must hold; the monitor samples 1 ns before every rising
// edge and pops/compares all entries due in that slot. TC is checked when
// UPDOWN_COUNTER_TC_EN is defined.
module tb_updown_counter;

    localparam int unsigned W = 8;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         Enable;
    logic         Load;
    logic         UpDn;
    logic [W-1:0] Data;
    logic [W-1:0] Q;
`ifdef UPDOWN_COUNTER_TC_EN
    logic         TC;
`endif

    updown_counter #(.WIDTH(W)) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .Enable (Enable),
        .Load   (Load),
        .UpDn   (UpDn),
        .Data   (Data),
        .Q      (Q)
`ifdef UPDOWN_COUNTER_TC_EN
        ,
        .TC     (TC)
`endif
    );

    // Rising edges at 5, 15, 25 ...; inputs change on falling edges (multiples of 10).
    always #5 Clock = ~Clock;

    typedef struct {
        int unsigned  slot;
        bit           is_tc;
        logic [W-1:0] val;
        string        name;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int unsigned  stim_slot = 0;   // slot j = sample at time 10*j + 4
    int unsigned  mon_slot = 0;
    logic [W-1:0] cur_q = '0;      // hand-computed counter value at the current slot

    function automatic logic tc_model(logic [W-1:0] q, logic rst, logic en, logic ld,
                                      logic updn);
        return !rst && en && !ld && ((updn && q == 8'hFF) || (!updn && q == 8'h00));
    endfunction

    task automatic push(int unsigned slot, bit is_tc, logic [W-1:0] v, string n);
        exp_t e;
        e.slot  = slot;
        e.is_tc = is_tc;
        e.val   = v;
        e.name  = n;
        sb.push_back(e);
    endtask

    // Apply inputs for the coming edge(s); TC is expected to reflect them right away.
    task automatic drive(logic en, logic ld, logic updn, logic [W-1:0] d);
        Enable = en;
        Load   = ld;
        UpDn   = updn;
        Data   = d;
`ifdef UPDOWN_COUNTER_TC_EN
        push(stim_slot, 1'b1, W'(tc_model(cur_q, Reset, en, ld, updn)), "tc");
`endif
    endtask

    // Let n edges pass and expect Q == exp afterwards.
    task automatic run(int unsigned n, logic [W-1:0] exp, string name);
        push(stim_slot + n, 1'b0, exp, name);
        cur_q = exp;
        repeat (n) begin
            @(negedge Clock);
            stim_slot++;
        end
    endtask

    // Monitor: compares everything due in this slot.
    initial begin
        exp_t         e;
        logic [W-1:0] act;
        #4;
        forever begin
            while (sb.size() > 0 && sb[0].slot <= mon_slot) begin
                e   = sb.pop_front();
                act = Q;
`ifdef UPDOWN_COUNTER_TC_EN
                if (e.is_tc) act = W'(TC);
`endif
                checks++;
                if (act !== e.val || e.slot != mon_slot) begin
                    errors++;
                    $display("FAIL %s slot %0d (due %0d) t=%0t: got %0h expected %0h",
                             e.name, mon_slot, e.slot, $time, act, e.val);
                end
            end
            mon_slot++;
            #10;
        end
    end

    initial begin
        // Reset asserted from t=0; Q cleared without waiting for an edge.
        Reset = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        push(stim_slot, 1'b0, 8'h00, "reset_async");
        run(1, 8'h00, "reset_hold");

        Reset = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        run(1, 8'h00, "idle_after_reset");

        // Count up, then down through zero.
        drive(1'b1, 1'b0, 1'b1, 8'h00);
        run(1, 8'h01, "up_1");
        run(1, 8'h02, "up_2");
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        run(1, 8'h01, "down_1");
        run(1, 8'h00, "down_0");
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        run(1, 8'hFF, "down_wrap");
        run(1, 8'hFE, "down_254");

        // Load beats enable; then up-wrap 255 -> 0.
        drive(1'b1, 1'b1, 1'b1, 8'hFD);
        run(1, 8'hFD, "load_with_en");
        drive(1'b1, 1'b0, 1'b1, 8'hAA);
        run(2, 8'hFF, "up_255");
        drive(1'b1, 1'b0, 1'b1, 8'hAA);
        run(1, 8'h00, "up_wrap");

        // Enable low: hold regardless of UpDn or Data.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, logic'(i % 2), 8'hA5);
            run(1, 8'h00, "hold");
        end
        drive(1'b0, 1'b1, 1'b0, 8'h5A);
        run(1, 8'h5A, "load_no_en");

        // Count to 37, then pulse reset between edges.
        drive(1'b0, 1'b1, 1'b1, 8'd35);
        run(1, 8'd35, "load_35");
        drive(1'b1, 1'b0, 1'b1, 8'h00);
        run(2, 8'd37, "count_37");
        drive(1'b0, 1'b0, 1'b1, 8'h00);
        push(stim_slot + 1, 1'b0, 8'h00, "mid_cycle_reset");
        cur_q = 8'h00;
        #6 Reset = 1'b1;
        #2 Reset = 1'b0;
        @(negedge Clock);
        stim_slot++;
        drive(1'b1, 1'b0, 1'b1, 8'h00);
        run(1, 8'h01, "after_reset_1");
        run(1, 8'h02, "after_reset_2");

        // Terminal-count scenarios (TC compared only when the feature is built).
        drive(1'b0, 1'b1, 1'b1, 8'hFF);
        run(1, 8'hFF, "load_ff");
        drive(1'b1, 1'b1, 1'b1, 8'h10);
        run(1, 8'h10, "load_over_tc");
        drive(1'b0, 1'b1, 1'b1, 8'hFF);
        run(1, 8'hFF, "load_ff_again");
        drive(1'b1, 1'b0, 1'b1, 8'h00);
        run(1, 8'h00, "tc_up_wrap");
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        run(1, 8'hFF, "tc_down_wrap");

        drive(1'b0, 1'b0, 1'b1, 8'h00);
        for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge Clock);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
